// File: rtl/fpa_ctrl_pkg.sv
// Shared definitions for the floating-point adder sharing controller.
//   WORD_W  : operand / result width (IEEE-754 single)
//   fsm_e   : halt/drain FSM encoding
//   POS_INF, QNAN : IEEE special values handy for benches and callers
package fpa_ctrl_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fsm_e;

    localparam logic [WORD_W-1:0] POS_INF = 32'h7F80_0000;
    localparam logic [WORD_W-1:0] QNAN    = 32'h7FC0_0000;

endpackage

// File: rtl/fpa_share_ctrl_rr_arbiter.sv
// Round-robin arbiter. Searches req starting one past ptr (modulo N) and
// grants the first requester found.
//   req : request vector
//   ptr : index of the last granted requester
//   en  : grant enable; gnt is zero when low
//   gnt : one-hot (or zero) grant
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt
);

    logic found;

    // Outer loop walks the search order ptr+1, ptr+2, ...; the inner loop
    // maps that position back to a constant bit index.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int off = 1; off <= N; off++) begin
            for (int i = 0; i < N; i++) begin
                if (en && !found && req[i] && (i == (int'(ptr) + off) % N)) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fpa_share_ctrl.sv
// Shares one pipelined FP adder among N requesters.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/a/b       : per-requester operand pairs (slice i = requester i)
//   req_ready           : one-hot grant, transfer on valid & ready
//   fpa_a/fpa_b         : registered operands to the adder
//   fpa_c               : adder result, LATENCY cycles after fpa_a/fpa_b
//   res_valid/res_data  : one-cycle result pulse tagged with requester id
//   halt, idle          : quiesce request / quiesced status
//   inflight            : operations issued but not yet returned
module fpa_share_ctrl
    import fpa_ctrl_pkg::*;
#(
    parameter int N       = 4,
    parameter int LATENCY = 6,
    parameter int CNT_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req_valid,
    input  logic [WORD_W*N-1:0]   req_a,
    input  logic [WORD_W*N-1:0]   req_b,
    output logic [N-1:0]          req_ready,
    output logic [WORD_W-1:0]     fpa_a,
    output logic [WORD_W-1:0]     fpa_b,
    input  logic [WORD_W-1:0]     fpa_c,
    output logic [N-1:0]          res_valid,
    output logic [WORD_W-1:0]     res_data,
    input  logic                  halt,
    output logic                  idle,
    output logic [CNT_W-1:0]      inflight
);

    localparam int PW = $clog2(N);

    fsm_e                    state_q;
    logic                    idle_q;
    logic [PW-1:0]           ptr_q;
    logic [WORD_W-1:0]       fpa_a_q, fpa_b_q, res_data_q;
    logic [N-1:0]            res_valid_q;
    logic [CNT_W-1:0]        cnt_q;

    // Tag stage 0 travels alongside fpa_a/fpa_b, so stage LATENCY lines up
    // with the matching fpa_c.
    logic [LATENCY:0]        tag_vld_q;
    logic [LATENCY:0][PW-1:0] tag_id_q;

    logic                    grant_en;
    logic [N-1:0]            gnt;
    logic                    xfer;
    logic                    ret;
    logic [PW-1:0]           gnt_idx;
    logic [WORD_W-1:0]       sel_a, sel_b;

    assign grant_en = (state_q == RUN) && !halt;

    rr_arbiter #(.N(N)) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .en  (grant_en),
        .gnt (gnt)
    );

    // gnt only ever selects a valid requester, so any grant is a transfer.
    assign xfer = |gnt;
    assign ret  = tag_vld_q[LATENCY];

    // Operand mux; zero on a bubble so the adder sees clean inputs.
    always_comb begin
        gnt_idx = '0;
        sel_a   = '0;
        sel_b   = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                gnt_idx = PW'(i);
                sel_a   = req_a[i*WORD_W +: WORD_W];
                sel_b   = req_b[i*WORD_W +: WORD_W];
            end
        end
    end

    // Issue, tag pipeline, result capture and in-flight count.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpa_a_q     <= '0;
            fpa_b_q     <= '0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            res_valid_q <= '0;
            res_data_q  <= '0;
            cnt_q       <= '0;
            ptr_q       <= PW'(N - 1);
        end else begin
            fpa_a_q   <= sel_a;
            fpa_b_q   <= sel_b;
            tag_vld_q <= {tag_vld_q[LATENCY-1:0], xfer};
            tag_id_q  <= {tag_id_q[LATENCY-1:0], gnt_idx};
            if (xfer) ptr_q <= gnt_idx;

            for (int i = 0; i < N; i++)
                res_valid_q[i] <= ret && (tag_id_q[LATENCY] == PW'(i));
            if (ret) res_data_q <= fpa_c;

            // The count drops on the edge that launches res_valid, so it
            // tracks exactly the valid tags and peaks at LATENCY+1.
            case ({xfer, ret})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Halt/drain FSM. A deasserted halt in DRAIN wins over draining to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            idle_q  <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    idle_q <= 1'b0;
                    if (halt) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (!halt) begin
                        state_q <= RUN;
                    end else if (cnt_q == '0) begin
                        state_q <= HALTED;
                        idle_q  <= 1'b1;
                    end
                end
                HALTED: begin
                    if (!halt) begin
                        state_q <= RUN;
                        idle_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= RUN;
                    idle_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = gnt;
    assign fpa_a     = fpa_a_q;
    assign fpa_b     = fpa_b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign idle      = idle_q;
    assign inflight  = cnt_q;

endmodule
